// File: rtl/pixel_write_arbiter.sv
// Purpose: shares the pixelStore write port between brush stamps (1x1/3x3, clipped) and a full-canvas clear.
// Latency: request seen in IDLE at edge N -> ack/busy/first write in cycle N+1; one pixel per cycle after that.
// Backpressure: brushReq is held unacked while busy or while a clear is pending; clears always win in IDLE.
module pixel_write_arbiter #(
  parameter int         WIDTH    = 160,
  parameter int         HEIGHT   = 120,
  parameter logic [2:0] BG_COLOR = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       brushReq,
  output logic       brushAck,
  input  logic [7:0] brushX,
  input  logic [7:0] brushY,
  input  logic [2:0] brushColor,
  input  logic       brushSize,
  input  logic       clearReq,
  output logic       busy,
  output logic       clearDone,
  output logic       brush,
  output logic [2:0] newColor,
  output logic [7:0] wx,
  output logic [7:0] wy
);

  typedef enum logic [1:0] {IDLE, STAMP, CLEAR} state_t;

  typedef struct packed {
    logic       ok;
    logic [7:0] x;
    logic [7:0] y;
  } pix_t;

  localparam logic [7:0] XMAX = 8'(WIDTH - 1);
  localparam logic [7:0] YMAX = 8'(HEIGHT - 1);
  // Stamp index 9 means "all offsets emitted"; a 1x1 stamp jumps straight to it.
  localparam logic [3:0] IDX_END = 4'd9;

  state_t     state_q, state_d;
  logic       pend_q, pend_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] sx_q, sx_d, sy_q, sy_d;
  logic [2:0] scol_q, scol_d;
  logic [7:0] cx_q, cx_d, cy_q, cy_d;
  logic       ack_q, ack_d, busy_q, busy_d, done_q, done_d, brush_q, brush_d;
  logic [2:0] col_q, col_d;
  logic [7:0] wx_q, wx_d, wy_q, wy_d;
  pix_t       pix;

  // Offset k of a 3x3 stamp (raster order, dy outer) around (cx,cy), clipped to the canvas.
  // Index 4 is the centre, which is also what a 1x1 stamp writes.
  function automatic pix_t stamp_pix(input logic [7:0] cx, input logic [7:0] cy,
                                     input logic [3:0] k);
    logic signed [8:0] ox, oy, px, py;
    pix_t p;
    case (k)
      4'd0, 4'd1, 4'd2: oy = -9'sd1;
      4'd3, 4'd4, 4'd5: oy = 9'sd0;
      default:          oy = 9'sd1;
    endcase
    case (k)
      4'd0, 4'd3, 4'd6: ox = -9'sd1;
      4'd1, 4'd4, 4'd7: ox = 9'sd0;
      default:          ox = 9'sd1;
    endcase
    px   = $signed({1'b0, cx}) + ox;
    py   = $signed({1'b0, cy}) + oy;
    // Negative and 256 both show up with bit 8 set, so they clip naturally.
    p.ok = !px[8] && !py[8] && ({1'b0, px[7:0]} < 9'(WIDTH)) && ({1'b0, py[7:0]} < 9'(HEIGHT));
    p.x  = p.ok ? px[7:0] : 8'd0;
    p.y  = p.ok ? py[7:0] : 8'd0;
    return p;
  endfunction

  // Next-state, arbitration and registered-output values.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    scol_d  = scol_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    brush_d = 1'b0;
    col_d   = 3'd0;
    wx_d    = 8'd0;
    wy_d    = 8'd0;
    pix     = (state_q == IDLE) ? stamp_pix(brushX, brushY, brushSize ? 4'd0 : 4'd4)
                                : stamp_pix(sx_q, sy_q, idx_q);
    case (state_q)
      IDLE: begin
        if (clearReq || pend_q) begin
          state_d = CLEAR;
          pend_d  = 1'b0;
          cx_d    = 8'd0;
          cy_d    = 8'd0;
          brush_d = 1'b1;
          col_d   = BG_COLOR;
        end else if (brushReq) begin
          state_d = STAMP;
          ack_d   = 1'b1;
          sx_d    = brushX;
          sy_d    = brushY;
          scol_d  = brushColor;
          idx_d   = brushSize ? 4'd1 : IDX_END;
          brush_d = pix.ok;
          col_d   = pix.ok ? brushColor : 3'd0;
          wx_d    = pix.x;
          wy_d    = pix.y;
        end
      end
      STAMP: begin
        pend_d = pend_q | clearReq;
        if (idx_q == IDX_END) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
          brush_d = pix.ok;
          col_d   = pix.ok ? scol_q : 3'd0;
          wx_d    = pix.x;
          wy_d    = pix.y;
        end
      end
      CLEAR: begin
        if (cx_q == XMAX && cy_q == YMAX) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          if (cx_q == XMAX) begin
            cx_d = 8'd0;
            cy_d = cy_q + 8'd1;
          end else begin
            cx_d = cx_q + 8'd1;
          end
          brush_d = 1'b1;
          col_d   = BG_COLOR;
          wx_d    = cx_d;
          wy_d    = cy_d;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any stamp or clear in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      idx_q   <= 4'd0;
      sx_q    <= 8'd0;
      sy_q    <= 8'd0;
      scol_q  <= 3'd0;
      cx_q    <= 8'd0;
      cy_q    <= 8'd0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      brush_q <= 1'b0;
      col_q   <= 3'd0;
      wx_q    <= 8'd0;
      wy_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      scol_q  <= scol_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      brush_q <= brush_d;
      col_q   <= col_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
    end
  end

  assign brushAck  = ack_q;
  assign busy      = busy_q;
  assign clearDone = done_q;
  assign brush     = brush_q;
  assign newColor  = col_q;
  assign wx        = wx_q;
  assign wy        = wy_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Bench for pixel_write_arbiter: a full-size canvas for stamps and a 4x3 canvas for clears.
// Expected write streams are computed per operation from canvas geometry and compared every cycle.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pixel_write_arbiter;

  localparam int         W0 = 160, H0 = 120;
  localparam int         W1 = 4,   H1 = 3;
  localparam logic [2:0] BG = 3'b111;

  logic       clk = 1'b0;
  logic       rst   [2];
  logic       breq  [2];
  logic       bsz   [2];
  logic       creq  [2];
  logic [7:0] bx    [2];
  logic [7:0] by    [2];
  logic [2:0] bc    [2];
  logic       ack_o [2];
  logic       busy_o[2];
  logic       done_o[2];
  logic       br_o  [2];
  logic [2:0] nc_o  [2];
  logic [7:0] wx_o  [2];
  logic [7:0] wy_o  [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pixel_write_arbiter #(.WIDTH(W0), .HEIGHT(H0), .BG_COLOR(BG)) dut_big (
    .clk(clk), .reset(rst[0]), .brushReq(breq[0]), .brushAck(ack_o[0]),
    .brushX(bx[0]), .brushY(by[0]), .brushColor(bc[0]), .brushSize(bsz[0]),
    .clearReq(creq[0]), .busy(busy_o[0]), .clearDone(done_o[0]), .brush(br_o[0]),
    .newColor(nc_o[0]), .wx(wx_o[0]), .wy(wy_o[0]));

  pixel_write_arbiter #(.WIDTH(W1), .HEIGHT(H1), .BG_COLOR(BG)) dut_small (
    .clk(clk), .reset(rst[1]), .brushReq(breq[1]), .brushAck(ack_o[1]),
    .brushX(bx[1]), .brushY(by[1]), .brushColor(bc[1]), .brushSize(bsz[1]),
    .clearReq(creq[1]), .busy(busy_o[1]), .clearDone(done_o[1]), .brush(br_o[1]),
    .newColor(nc_o[1]), .wx(wx_o[1]), .wy(wy_o[1]));

  function automatic int cw(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  function automatic int ch(input int d);
    return (d == 0) ? H0 : H1;
  endfunction

  // Output snapshot: {ack, busy, done, brush, colour, wx, wy}
  function automatic logic [22:0] obs(input int d);
    return {ack_o[d], busy_o[d], done_o[d], br_o[d], nc_o[d], wx_o[d], wy_o[d]};
  endfunction

  function automatic logic [22:0] mk(input bit a, input bit b, input bit dn, input bit w,
                                     input int c, input int x, input int y);
    return {a, b, dn, w, c[2:0], x[7:0], y[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (ack,busy,done,brush,col,wx,wy)", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Checks a stamp starting at its ack cycle; optionally pulses clearReq at offset clr_at.
  task automatic check_stamp(input int d, input int x, input int y, input int c,
                             input bit sz, input int clr_at);
    int n, dx, dy, px, py;
    bit in;
    n = sz ? 9 : 1;
    for (int k = 0; k < n; k++) begin
      dx = sz ? (k % 3) - 1 : 0;
      dy = sz ? (k / 3) - 1 : 0;
      px = x + dx;
      py = y + dy;
      in = (px >= 0) && (px < cw(d)) && (py >= 0) && (py < ch(d));
      chk("stamp_px", obs(d), in ? mk(k == 0, 1, 0, 1, c, px, py) : mk(k == 0, 1, 0, 0, 0, 0, 0));
      if (k == 0) breq[d] = 1'b0;
      creq[d] = (k == clr_at);
      cyc();
    end
    creq[d] = 1'b0;
    chk("stamp_end", obs(d), mk(0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic stamp(input int d, input int x, input int y, input int c, input bit sz);
    bx[d] = 8'(x); by[d] = 8'(y); bc[d] = 3'(c); bsz[d] = sz; breq[d] = 1'b1;
    cyc();
    check_stamp(d, x, y, c, sz, -1);
  endtask

  // Checks a clear starting at its first write; pulses clearReq at write index mid.
  task automatic check_clear(input int d, input int mid);
    for (int i = 0; i < cw(d) * ch(d); i++) begin
      chk("clear_px", obs(d), mk(0, 1, 0, 1, BG, i % cw(d), i / cw(d)));
      creq[d] = (i == mid);
      cyc();
    end
    creq[d] = 1'b0;
    chk("clear_done", obs(d), mk(0, 0, 1, 0, 0, 0, 0));
  endtask

  // Clear request, optionally together with a brush request that must wait for clearDone.
  task automatic clear(input int d, input int mid, input bit wb,
                       input int x, input int y, input int c, input bit sz);
    creq[d] = 1'b1;
    if (wb) begin
      bx[d] = 8'(x); by[d] = 8'(y); bc[d] = 3'(c); bsz[d] = sz; breq[d] = 1'b1;
    end
    cyc();
    creq[d] = 1'b0;
    check_clear(d, mid);
    cyc();
    if (wb) check_stamp(d, x, y, c, sz, -1);
    else    chk("idle_after_clear", obs(d), mk(0, 0, 0, 0, 0, 0, 0));
  endtask

  function automatic int pick(input int lim);
    case ($urandom_range(0, 4))
      0:       return 0;
      1:       return lim - 1;
      2:       return lim;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int x, y, c;
    bit sz;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; breq[d] = 1'b0; bsz[d] = 1'b0; creq[d] = 1'b0;
      bx[d] = 8'd0; by[d] = 8'd0; bc[d] = 3'd0;
    end
    @(negedge clk);
    cyc();
    chk("reset_big", obs(0), mk(0, 0, 0, 0, 0, 0, 0));
    chk("reset_small", obs(1), mk(0, 0, 0, 0, 0, 0, 0));
    rst[0] = 1'b0; rst[1] = 1'b0;
    cyc();

    // Directed stamps on the full canvas, back to back.
    stamp(0, 100, 100, 3'b010, 1'b0);
    stamp(0, 50, 60, 3'b101, 1'b1);
    stamp(0, 0, 0, 3'b011, 1'b1);
    stamp(0, W0 - 1, H0 - 1, 3'b110, 1'b1);
    stamp(0, 255, 255, 3'b001, 1'b1);
    stamp(0, 7, 9, 3'b100, 1'b0);

    // Clear on the small canvas, with a clearReq pulse mid-clear that must be dropped.
    clear(1, 5, 1'b0, 0, 0, 0, 1'b0);
    // Simultaneous clear and brush: clear first, stamp after clearDone.
    clear(1, -1, 1'b1, 1, 1, 3'b010, 1'b1);

    // clearReq during a 3x3 stamp: stamp completes, one idle cycle, then the clear.
    bx[1] = 8'd3; by[1] = 8'd2; bc[1] = 3'b101; bsz[1] = 1'b1; breq[1] = 1'b1;
    cyc();
    check_stamp(1, 3, 2, 3'b101, 1'b1, 2);
    cyc();
    check_clear(1, -1);
    cyc();
    chk("idle_after_pend_clear", obs(1), mk(0, 0, 0, 0, 0, 0, 0));

    // Reset asserted during the fifth clear write.
    creq[1] = 1'b1;
    cyc();
    creq[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("clear_px_pre_reset", obs(1), mk(0, 1, 0, 1, BG, i % W1, i / W1));
      if (i == 4) rst[1] = 1'b1;
      cyc();
    end
    chk("reset_mid_clear", obs(1), mk(0, 0, 0, 0, 0, 0, 0));
    rst[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("no_done_after_reset", obs(1), mk(0, 0, 0, 0, 0, 0, 0));
    end
    stamp(1, 2, 1, 3'b011, 1'b0);

    // Randomized mix of operations on both canvases.
    for (int it = 0; it < 60; it++) begin
      c  = int'($urandom_range(0, 7));
      sz = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0, 1: begin
          x = pick(W0);
          y = pick(H0);
          stamp(0, x, y, c, sz);
        end
        2: begin
          x = int'($urandom_range(0, 5));
          y = int'($urandom_range(0, 4));
          stamp(1, x, y, c, sz);
        end
        default: begin
          x = int'($urandom_range(0, 5));
          y = int'($urandom_range(0, 4));
          clear(1, int'($urandom_range(0, 14)) - 1, 1'($urandom_range(0, 1)), x, y, c, sz);
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
